// File: rtl/atb_source_if.sv
`timescale 1ns/1ps
// atb_source_if: ATB link between a trace source (master) and sink (slave).
//   atvalid/atready     transfer handshake
//   atdata/atbytes/atid payload (atbytes = valid bytes - 1)
//   afvalid/afready     flush request (sink) / acknowledge (source)
//   syncreq             sync request from the sink
interface atb_source_if;
  logic        atvalid;
  logic        atready;
  logic [31:0] atdata;
  logic [2:0]  atbytes;
  logic [6:0]  atid;
  logic        afvalid;
  logic        afready;
  logic        syncreq;

  modport master (
    output atvalid, atdata, atbytes, atid, afready,
    input  atready, afvalid, syncreq
  );

  modport slave (
    input  atvalid, atdata, atbytes, atid, afready,
    output atready, afvalid, syncreq
  );
endinterface

// File: rtl/atb_source.sv
`timescale 1ns/1ps
// atb_source: ATB trace source. Buffers words from a local trace generator
// and drives them onto the ATB link, honouring back-pressure, flush and sync.
//   atclk/atresetn/atclken  clock, async active-low reset, clock enable
//   in_valid/in_ready       generator push handshake (in_ready = !full)
//   in_data/in_bytes        trace word and valid bytes - 1
//   atid_cfg                trace source ID to transmit with
//   atb (master)            ATB transfer, flush and syncreq signals
//   sync_pulse              one-cycle sync request towards the generator
//   atwakeup                source holds or is offered data
//   drop_cnt                saturating count of words dropped for a reserved ID
module atb_source #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic              atclk,
  input  logic              atresetn,
  input  logic              atclken,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic [2:0]        in_bytes,
  input  logic [6:0]        atid_cfg,
  atb_source_if.master      atb,
  output logic              sync_pulse,
  output logic              atwakeup,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  bytes;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_ACK, S_WAIT} fl_state_t;

  function automatic logic reserved(input logic [6:0] id);
    return (id == 7'h00) || (id >= 7'h70 && id <= 7'h7C) || (id >= 7'h7E);
  endfunction

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic [6:0]      id_q;
  logic            empty, id_ok, valid, stall;
  logic            push, pop, drop;
  entry_t          head;

  fl_state_t       st_q, st_d;
  logic [CW-1:0]   fl_q, fl_d;

  assign empty    = (count == '0);
  assign in_ready = (count != FULL_CNT);
  assign id_ok    = !reserved(id_q);
  assign valid    = !empty && id_ok;
  assign stall    = valid && !atb.atready;
  assign head     = mem[rptr];

  // A pop either hands the head to the sink or discards it because the
  // current ID must never appear on the bus.
  assign push = atclken && in_valid && in_ready;
  assign drop = atclken && !empty && !id_ok;
  assign pop  = (atclken && valid && atb.atready) || drop;

  assign atb.atvalid = valid;
  assign atb.atdata  = valid ? head.data  : 32'h0;
  assign atb.atbytes = valid ? head.bytes : 3'h0;
  assign atb.atid    = id_q;

  // Storage needs no reset: nothing is read unless count says it is valid.
  always_ff @(posedge atclk) begin
    if (push) mem[wptr] <= '{data: in_data, bytes: in_bytes};
  end

  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ID is frozen while a transfer is stalled so the sink sees a stable beat.
  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn)               id_q <= '0;
    else if (atclken && !stall)  id_q <= atid_cfg;
  end

  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      drop_cnt   <= '0;
      sync_pulse <= 1'b0;
      atwakeup   <= 1'b0;
    end else if (atclken) begin
      if (drop && drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
      sync_pulse <= atb.syncreq;
      atwakeup   <= !empty || in_valid;
    end
  end

  // Flush FSM: state register
  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      st_q <= S_IDLE;
      fl_q <= '0;
    end else if (atclken) begin
      st_q <= st_d;
      fl_q <= fl_d;
    end
  end

  // Flush FSM: next state. The snapshot excludes a word leaving on the
  // request edge itself, so that pop is never waited for a second time.
  // Words pushed after the request are never counted.
  always_comb begin
    st_d = st_q;
    fl_d = fl_q;
    case (st_q)
      S_IDLE: begin
        if (atb.afvalid) begin
          fl_d = count - {{(CW-1){1'b0}}, pop};
          st_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fl_q == '0) begin
          st_d = S_ACK;
        end else if (pop) begin
          fl_d = fl_q - 1'b1;
          if (fl_q == {{(CW-1){1'b0}}, 1'b1}) st_d = S_ACK;
        end
      end
      S_ACK:   st_d = S_WAIT;
      S_WAIT:  if (!atb.afvalid) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  // Flush FSM: outputs
  always_comb begin
    atb.afready = (st_q == S_ACK);
  end

endmodule
